// File: rtl/controlador_rpn.sv
// Sequencer for the RPN calculator: drives push/pop strobes for a small operand stack,
// runs the ULA start/ready handshake and writes the result back, trapping stack/ULA faults.
module controlador_rpn #(
    parameter int PROFUNDIDADE   = 4,
    parameter int TIMEOUT_CICLOS = 16,
    parameter int LARGURA        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               entrada_numero,
    input  logic               entrada_operacao,
    input  logic [LARGURA-1:0] dado_entrada,
    input  logic [2:0]         operacao,
    input  logic               ula_pronto,
    input  logic               ula_erro,
    input  logic [LARGURA-1:0] resultado_ula,
    input  logic               limpar_erro,
    output logic               push,
    output logic               pop,
    output logic [LARGURA-1:0] dado_push,
    output logic               ula_start,
    output logic [2:0]         operacao_ula,
    output logic [2:0]         contagem,
    output logic               pilha_vazia,
    output logic               pilha_cheia,
    output logic               ocupado,
    output logic               erro,
    output logic [1:0]         codigo_erro
);
    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [2:0]    PROF    = 3'(PROFUNDIDADE);
    localparam logic [TW-1:0] TMO_ULT = TW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [2:0] {
        OCIOSO, PUSH_NUM, EXEC, ESPERA, POP1, POP2, PUSH_RES, ERRO
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [2:0]         contagem_q, contagem_d;
    logic [LARGURA-1:0] dado_q, dado_d;
    logic [2:0]         op_q, op_d;
    logic [1:0]         cod_q, cod_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [2:0]         necessario;

    // Unary ops (11x) consume one operand, everything else two.
    assign necessario = (operacao[2:1] == 2'b11) ? 3'd1 : 3'd2;

    always_comb begin
        estado_d   = estado_q;
        contagem_d = contagem_q;
        dado_d     = dado_q;
        op_d       = op_q;
        cod_d      = cod_q;
        tmo_d      = tmo_q;
        case (estado_q)
            OCIOSO: begin
                if (entrada_numero) begin
                    if (contagem_q == PROF) begin
                        estado_d = ERRO;
                        cod_d    = 2'b10;
                    end else begin
                        dado_d   = dado_entrada;
                        estado_d = PUSH_NUM;
                    end
                end else if (entrada_operacao) begin
                    if (contagem_q < necessario) begin
                        estado_d = ERRO;
                        cod_d    = 2'b01;
                    end else begin
                        op_d     = operacao;
                        estado_d = EXEC;
                    end
                end
            end
            PUSH_NUM: begin
                contagem_d = contagem_q + 3'd1;
                estado_d   = OCIOSO;
            end
            EXEC: begin
                tmo_d    = '0;
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (ula_pronto) begin
                    if (ula_erro) begin
                        estado_d = ERRO;
                        cod_d    = 2'b11;
                    end else begin
                        dado_d   = resultado_ula;
                        estado_d = POP1;
                    end
                end else if (tmo_q == TMO_ULT) begin
                    estado_d = ERRO;
                    cod_d    = 2'b11;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            POP1: begin
                contagem_d = contagem_q - 3'd1;
                estado_d   = (op_q[2:1] == 2'b11) ? PUSH_RES : POP2;
            end
            POP2: begin
                contagem_d = contagem_q - 3'd1;
                estado_d   = PUSH_RES;
            end
            PUSH_RES: begin
                contagem_d = contagem_q + 3'd1;
                estado_d   = OCIOSO;
            end
            ERRO: begin
                if (limpar_erro) begin
                    cod_d    = 2'b00;
                    estado_d = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q   <= OCIOSO;
            contagem_q <= '0;
            dado_q     <= '0;
            op_q       <= '0;
            cod_q      <= '0;
            tmo_q      <= '0;
        end else begin
            estado_q   <= estado_d;
            contagem_q <= contagem_d;
            dado_q     <= dado_d;
            op_q       <= op_d;
            cod_q      <= cod_d;
            tmo_q      <= tmo_d;
        end
    end

    // Every output comes straight from state or a register.
    assign push         = (estado_q == PUSH_NUM) || (estado_q == PUSH_RES);
    assign pop          = (estado_q == POP1) || (estado_q == POP2);
    assign ula_start    = (estado_q == EXEC);
    assign dado_push    = dado_q;
    assign operacao_ula = op_q;
    assign contagem     = contagem_q;
    assign pilha_vazia  = (contagem_q == 3'd0);
    assign pilha_cheia  = (contagem_q == PROF);
    assign ocupado      = (estado_q != OCIOSO);
    assign erro         = (estado_q == ERRO);
    assign codigo_erro  = cod_q;
endmodule

// File: tb/tb_controlador_rpn.sv
// Bench for controlador_rpn: table of key/ULA transactions checked against expected stack state,
// with a queue of expected push data, plus hand-written timeout, reset and collision sequences.
module tb_controlador_rpn;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entrada_numero = 1'b0, entrada_operacao = 1'b0;
    logic [7:0] dado_entrada = '0;
    logic [2:0] operacao = '0;
    logic       ula_pronto = 1'b0, ula_erro = 1'b0;
    logic [7:0] resultado_ula = '0;
    logic       limpar_erro = 1'b0;
    logic       push, pop, ula_start, pilha_vazia, pilha_cheia, ocupado, erro;
    logic [7:0] dado_push;
    logic [2:0] operacao_ula, contagem;
    logic [1:0] codigo_erro;

    controlador_rpn #(.PROFUNDIDADE(4), .TIMEOUT_CICLOS(16), .LARGURA(8)) dut (
        .clk(clk), .rst(rst),
        .entrada_numero(entrada_numero), .entrada_operacao(entrada_operacao),
        .dado_entrada(dado_entrada), .operacao(operacao),
        .ula_pronto(ula_pronto), .ula_erro(ula_erro), .resultado_ula(resultado_ula),
        .limpar_erro(limpar_erro),
        .push(push), .pop(pop), .dado_push(dado_push), .ula_start(ula_start),
        .operacao_ula(operacao_ula), .contagem(contagem),
        .pilha_vazia(pilha_vazia), .pilha_cheia(pilha_cheia),
        .ocupado(ocupado), .erro(erro), .codigo_erro(codigo_erro)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_num;
        logic [7:0] dado;
        logic [2:0] op;
        logic [7:0] res;
        int         atraso;   // ESPERA cycle in which ula_pronto rises; 0 = ULA not involved
        bit         uerr;
        int         exp_cont;
        logic [1:0] exp_cod;
        int         exp_pops;
        int         exp_busy;
    } vec_t;

    vec_t       tab[12];
    int         checks = 0, errors = 0;
    int         busy_cnt = 0, pop_cnt = 0, start_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nome, act, exp);
        end
    endtask

    // One clock of observation; every wait in the bench goes through here.
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            if (ocupado && !erro) busy_cnt++;
            if (pop) pop_cnt++;
            if (ula_start) start_cnt++;
            chk("push_pop_exclusive", {31'd0, push & pop}, 32'd0);
            chk("contagem_range", {31'd0, contagem <= 3'd4}, 32'd1);
            if (push) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_push: got dado_push %0h expected no push", dado_push);
                end else begin
                    chk("dado_push", 32'(dado_push), 32'(exp_q.pop_front()));
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (ocupado && n < 60) begin tick(); n++; end
        chk("idle_timeout", {31'd0, ocupado}, 32'd0);
    endtask

    task automatic apply_row(input vec_t v, input int idx);
        int n;
        string s;
        s = $sformatf("row%0d", idx);
        wait_idle();
        busy_cnt = 0; pop_cnt = 0;
        if (v.exp_cod == 2'b00) exp_q.push_back(v.is_num ? v.dado : v.res);
        entrada_numero   = v.is_num;
        entrada_operacao = !v.is_num;
        dado_entrada     = v.dado;
        operacao         = v.op;
        tick();
        entrada_numero = 1'b0; entrada_operacao = 1'b0;
        if (v.atraso > 0) begin
            n = 0;
            while (!ula_start && n < 4) begin tick(); n++; end
            chk({s, "_ula_start"}, {31'd0, ula_start}, 32'd1);
            repeat (v.atraso) tick();
            ula_pronto = 1'b1; ula_erro = v.uerr; resultado_ula = v.res;
            tick();
            ula_pronto = 1'b0; ula_erro = 1'b0;
        end
        n = 0;
        while (ocupado && !erro && n < 60) begin tick(); n++; end
        chk({s, "_contagem"}, 32'(contagem), 32'(v.exp_cont));
        chk({s, "_codigo_erro"}, 32'(codigo_erro), 32'(v.exp_cod));
        chk({s, "_erro"}, {31'd0, erro}, {31'd0, v.exp_cod != 2'b00});
        chk({s, "_pilha_vazia"}, {31'd0, pilha_vazia}, {31'd0, v.exp_cont == 0});
        chk({s, "_pilha_cheia"}, {31'd0, pilha_cheia}, {31'd0, v.exp_cont == 4});
        chk({s, "_pops"}, 32'(pop_cnt), 32'(v.exp_pops));
        if (v.exp_cod == 2'b00) chk({s, "_busy_cycles"}, 32'(busy_cnt), 32'(v.exp_busy));
        if (v.atraso > 0 && v.exp_cod == 2'b00) chk({s, "_operacao_ula"}, 32'(operacao_ula), 32'(v.op));
        if (erro) begin
            limpar_erro = 1'b1;
            tick();
            limpar_erro = 1'b0;
            chk({s, "_clear_erro"}, {31'd0, erro}, 32'd0);
            chk({s, "_clear_codigo"}, 32'(codigo_erro), 32'd0);
            chk({s, "_clear_contagem"}, 32'(contagem), 32'(v.exp_cont));
        end
    endtask

    initial begin
        int n;
        //          num  dado   op    res   atr uerr cont cod   pops busy
        tab[0]  = '{1, 8'h05, 3'd0, 8'h00, 0,  0,  1, 2'b00, 0, 1};
        tab[1]  = '{1, 8'h03, 3'd0, 8'h00, 0,  0,  2, 2'b00, 0, 1};
        tab[2]  = '{0, 8'h00, 3'd0, 8'h08, 2,  0,  1, 2'b00, 2, 6};
        tab[3]  = '{0, 8'h00, 3'd6, 8'h2A, 1,  0,  1, 2'b00, 1, 4};
        tab[4]  = '{0, 8'h00, 3'd0, 8'h00, 0,  0,  1, 2'b01, 0, 0};
        tab[5]  = '{1, 8'h11, 3'd0, 8'h00, 0,  0,  2, 2'b00, 0, 1};
        tab[6]  = '{1, 8'h22, 3'd0, 8'h00, 0,  0,  3, 2'b00, 0, 1};
        tab[7]  = '{1, 8'h33, 3'd0, 8'h00, 0,  0,  4, 2'b00, 0, 1};
        tab[8]  = '{1, 8'h44, 3'd0, 8'h00, 0,  0,  4, 2'b10, 0, 0};
        tab[9]  = '{0, 8'h00, 3'd1, 8'hAA, 1,  1,  4, 2'b11, 0, 0};
        tab[10] = '{0, 8'h00, 3'd3, 8'h77, 15, 0,  3, 2'b00, 2, 19};
        tab[11] = '{0, 8'h00, 3'd7, 8'h3C, 3,  0,  3, 2'b00, 1, 6};

        repeat (2) @(negedge clk);
        chk("rst_contagem", 32'(contagem), 32'd0);
        chk("rst_strobes", {29'd0, push, pop, ula_start}, 32'd0);
        chk("rst_dado_push", 32'(dado_push), 32'd0);
        chk("rst_operacao_ula", 32'(operacao_ula), 32'd0);
        chk("rst_status", {28'd0, ocupado, erro, pilha_vazia, pilha_cheia}, 32'b0010);
        chk("rst_codigo_erro", 32'(codigo_erro), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) apply_row(tab[i], i);

        // Timeout: no ula_pronto; a number key pressed mid-wait must be dropped.
        wait_idle();
        pop_cnt = 0;
        entrada_operacao = 1'b1; operacao = 3'd2;
        tick();
        entrada_operacao = 1'b0;
        chk("tmo_ula_start", {31'd0, ula_start}, 32'd1);
        n = 0;
        while (!erro && n < 40) begin
            tick(); n++;
            entrada_numero = (n == 3);
            dado_entrada   = 8'hEE;
        end
        entrada_numero = 1'b0;
        chk("tmo_cycles_to_erro", 32'(n), 32'd17);
        chk("tmo_codigo_erro", 32'(codigo_erro), 32'd3);
        chk("tmo_contagem", 32'(contagem), 32'd3);
        chk("tmo_pops", 32'(pop_cnt), 32'd0);
        limpar_erro = 1'b1; tick(); limpar_erro = 1'b0;
        chk("tmo_clear", {30'd0, erro, ocupado}, 32'd0);

        // Reset while in POP1 abandons the op; the result is never pushed.
        entrada_operacao = 1'b1; operacao = 3'd0;
        tick();
        entrada_operacao = 1'b0;
        tick();
        ula_pronto = 1'b1; resultado_ula = 8'h99;
        tick();
        ula_pronto = 1'b0;
        chk("rstpop_pop_seen", {31'd0, pop}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rstpop_ocupado", {31'd0, ocupado}, 32'd0);
        chk("rstpop_contagem", 32'(contagem), 32'd0);
        chk("rstpop_strobes", {29'd0, push, pop, ula_start}, 32'd0);
        chk("rstpop_dado_push", 32'(dado_push), 32'd0);
        #2 rst = 1'b0;
        tick();

        // Number and op together in OCIOSO: number wins, op dropped.
        start_cnt = 0;
        exp_q.push_back(8'h5A);
        entrada_numero = 1'b1; entrada_operacao = 1'b1; operacao = 3'd0; dado_entrada = 8'h5A;
        tick();
        entrada_numero = 1'b0; entrada_operacao = 1'b0;
        wait_idle();
        repeat (3) tick();
        chk("both_contagem", 32'(contagem), 32'd1);
        chk("both_codigo_erro", 32'(codigo_erro), 32'd0);
        chk("both_no_start", 32'(start_cnt), 32'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
